// File: rtl/edge_event_arbiter_amisha.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter_amisha
//
// Multi-channel edge-event scheduler. Rising edges on N already-synchronous
// level inputs are latched as per-channel pending events. A round-robin arbiter
// then hands them, one at a time, to a single consumer over valid/ready.
//
// Optional feature macro: EDGE_ARB_FALLING_EN
//   defined   : falling edges also raise events; each channel remembers the
//               polarity of its pending event and event_rise_amisha reports it.
//   undefined : rising edges only; event_rise_amisha is 1 with every offer.
//
// Ports
//   clk_amisha           in   1    system clock, rising edge
//   reset_amisha         in   1    asynchronous, active-high reset
//   level_amisha         in   N    level inputs (synchronous to clk_amisha)
//   event_valid_amisha   out  1    event offered to the consumer (registered)
//   event_ready_amisha   in   1    consumer accepts the offered event
//   event_id_amisha      out  IDW  channel of the offered event (registered)
//   event_rise_amisha    out  1    polarity of the offered event, 1 = rising
//   pending_amisha       out  N    per-channel pending flags
//   overflow_amisha      out  N    sticky per-channel "event lost" flags
//   overflow_clr_amisha  in   1    single-cycle pulse clearing all overflows
//
// Parameters
//   N   number of channels, 2..16
//   IDW width of event_id, ceil(log2(N)), minimum 1
// -----------------------------------------------------------------------------
module edge_event_arbiter_amisha #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic           clk_amisha,
   input  logic           reset_amisha,
   input  logic [N-1:0]   level_amisha,
   output logic           event_valid_amisha,
   input  logic           event_ready_amisha,
   output logic [IDW-1:0] event_id_amisha,
   output logic           event_rise_amisha,
   output logic [N-1:0]   pending_amisha,
   output logic [N-1:0]   overflow_amisha,
   input  logic           overflow_clr_amisha
);

   // Two-bit encoding leaves room for unreachable codes, which the FSM
   // recovers from by returning to IDLE.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OFFER = 2'd1
   } state_t;

   // Wrap-around constant for the round-robin search; one extra bit so that
   // last_grant + N never overflows.
   localparam logic [IDW:0]   N_W       = (IDW+1)'(N);
   localparam logic [IDW-1:0] LAST_RST  = IDW'(N-1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t         state_q, state_d;
   logic [N-1:0]   level_prev_q;
   logic [N-1:0]   pending_q, pending_d;
   logic [N-1:0]   overflow_q, overflow_d;
   logic           valid_q, valid_d;
   logic [IDW-1:0] id_q, id_d;
   logic           rise_q, rise_d;
   logic [IDW-1:0] last_q, last_d;
`ifdef EDGE_ARB_FALLING_EN
   logic [N-1:0]   pol_q, pol_d;
`endif

   // ---------------------------------------------------------------------------
   // Edge detection
   // ---------------------------------------------------------------------------
   logic [N-1:0] rise_det;
   logic [N-1:0] edge_det;

   assign rise_det = level_amisha & ~level_prev_q;
`ifdef EDGE_ARB_FALLING_EN
   logic [N-1:0] fall_det;
   assign fall_det = ~level_amisha & level_prev_q;
   assign edge_det = rise_det | fall_det;
`else
   assign edge_det = rise_det;
`endif

   // ---------------------------------------------------------------------------
   // Handshake: acceptance only counts while actually offering.
   // ---------------------------------------------------------------------------
   logic         accept;
   logic [N-1:0] acc_vec;

   assign accept = (state_q == S_OFFER) && valid_q && event_ready_amisha;

   always_comb begin
      acc_vec = '0;
      for (int i = 0; i < N; i++) begin
         acc_vec[i] = accept && (id_q == IDW'(i));
      end
   end

   // ---------------------------------------------------------------------------
   // Pending / overflow / polarity update
   //   An edge on a channel that is pending and not being drained this cycle
   //   is lost and recorded as overflow; the existing pending event (and its
   //   polarity) is kept. An edge on the channel being accepted re-arms it.
   // ---------------------------------------------------------------------------
   logic [N-1:0] ovf_set;

   always_comb begin
      pending_d = pending_q;
      ovf_set   = '0;
`ifdef EDGE_ARB_FALLING_EN
      pol_d     = pol_q;
`endif
      for (int i = 0; i < N; i++) begin
         if (edge_det[i]) begin
            if (pending_q[i] && !acc_vec[i]) begin
               ovf_set[i] = 1'b1;
            end else begin
               pending_d[i] = 1'b1;
`ifdef EDGE_ARB_FALLING_EN
               pol_d[i]     = rise_det[i];
`endif
            end
         end else if (acc_vec[i]) begin
            pending_d[i] = 1'b0;
         end
      end
      // A new overflow beats a simultaneous clear.
      overflow_d = (overflow_q & ~{N{overflow_clr_amisha}}) | ovf_set;
   end

   // ---------------------------------------------------------------------------
   // Round-robin select: first pending channel above last_grant, wrapping.
   // ---------------------------------------------------------------------------
   logic           sel_found;
   logic [IDW-1:0] sel_id;
   logic [IDW:0]   cand;

   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      cand      = '0;
      for (int k = 1; k <= N; k++) begin
         cand = {1'b0, last_q} + (IDW+1)'(k);
         if (cand >= N_W) begin
            cand = cand - N_W;
         end
         if (!sel_found && pending_q[cand[IDW-1:0]]) begin
            sel_found = 1'b1;
            sel_id    = cand[IDW-1:0];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Offer FSM: next state and registered outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      id_d    = id_q;
      rise_d  = rise_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            if (sel_found) begin
               valid_d = 1'b1;
               id_d    = sel_id;
`ifdef EDGE_ARB_FALLING_EN
               rise_d  = pol_q[sel_id];
`else
               rise_d  = 1'b1;
`endif
               state_d = S_OFFER;
            end
         end
         S_OFFER: begin
            // id/rise stay frozen until the consumer takes the event.
            if (event_ready_amisha) begin
               valid_d = 1'b0;
               last_d  = id_q;
               state_d = S_IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         state_q      <= S_IDLE;
         level_prev_q <= '0;
         pending_q    <= '0;
         overflow_q   <= '0;
         valid_q      <= 1'b0;
         id_q         <= '0;
         rise_q       <= 1'b0;
         // Start one below channel 0 so channel 0 wins first.
         last_q       <= LAST_RST;
      end else begin
         state_q      <= state_d;
         level_prev_q <= level_amisha;
         pending_q    <= pending_d;
         overflow_q   <= overflow_d;
         valid_q      <= valid_d;
         id_q         <= id_d;
         rise_q       <= rise_d;
         last_q       <= last_d;
      end
   end

`ifdef EDGE_ARB_FALLING_EN
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         pol_q <= '0;
      end else begin
         pol_q <= pol_d;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign event_valid_amisha = valid_q;
   assign event_id_amisha    = id_q;
   assign event_rise_amisha  = rise_q;
   assign pending_amisha     = pending_q;
   assign overflow_amisha    = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter_amisha.sv
// Self-checking bench for edge_event_arbiter_amisha: directed scenarios with
// constant expectations plus a randomized run against an event-level model.
module tb_edge_event_arbiter_amisha;
   localparam int N   = 4;
   localparam int IDW = 2;
`ifdef EDGE_ARB_FALLING_EN
   localparam bit FALL_EN = 1'b1;
`else
   localparam bit FALL_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   lvl = '0;
   logic           rdy = 1'b0;
   logic           clr = 1'b0;
   logic           vld;
   logic [IDW-1:0] id;
   logic           rise;
   logic [N-1:0]   pend;
   logic [N-1:0]   ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   edge_event_arbiter_amisha #(.N(N), .IDW(IDW)) dut (
      .clk_amisha          (clk),
      .reset_amisha        (rst),
      .level_amisha        (lvl),
      .event_valid_amisha  (vld),
      .event_ready_amisha  (rdy),
      .event_id_amisha     (id),
      .event_rise_amisha   (rise),
      .pending_amisha      (pend),
      .overflow_amisha     (ovf),
      .overflow_clr_amisha (clr)
   );

   // ---------------------------------------------------------------------------
   // Reference model: per-channel event bookkeeping plus a single "offer slot"
   // ---------------------------------------------------------------------------
   logic [N-1:0] m_prev, m_pend, m_pol, m_ovf;
   bit           m_valid;
   int           m_id;
   bit           m_rise;
   int           m_last;

   task automatic model_reset();
      m_prev = '0; m_pend = '0; m_pol = '0; m_ovf = '0;
      m_valid = 1'b0; m_id = 0; m_rise = 1'b0; m_last = N - 1;
   endtask

   task automatic model_step(input logic [N-1:0] l, input logic r, input logic c);
      logic [N-1:0] np, npol, lost;
      bit acc, re, fe, hit;
      int ch;
      np = m_pend; npol = m_pol; lost = '0;
      acc = m_valid && r;
      for (int i = 0; i < N; i++) begin
         re  = l[i] && !m_prev[i];
         fe  = FALL_EN && !l[i] && m_prev[i];
         hit = acc && (m_id == i);
         if (re || fe) begin
            if (m_pend[i] && !hit) lost[i] = 1'b1;
            else begin np[i] = 1'b1; npol[i] = re; end
         end else if (hit) np[i] = 1'b0;
      end
      if (m_valid) begin
         if (r) begin m_valid = 1'b0; m_last = m_id; end
      end else begin
         for (int k = 1; k <= N; k++) begin
            ch = (m_last + k) % N;
            if (m_pend[ch]) begin
               m_valid = 1'b1; m_id = ch;
               m_rise = FALL_EN ? m_pol[ch] : 1'b1;
               break;
            end
         end
      end
      m_pend = np; m_pol = npol;
      m_ovf  = (c ? '0 : m_ovf) | lost;
      m_prev = l;
   endtask

   // Drive one cycle of inputs, advance DUT and model, return at posedge+1.
   task automatic cyc(input logic [N-1:0] l, input logic r, input logic c);
      lvl = l; rdy = r; clr = c;
      @(posedge clk);
      model_step(l, r, c);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; lvl = '0; rdy = 1'b0; clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if ({vld, id, rise, pend, ovf} !== '0) begin
         errors++;
         $display("FAIL reset_state got %b exp 0", {vld, id, rise, pend, ovf});
      end
      do_reset();
      checks++;
      if ({vld, pend, ovf} !== '0) begin
         errors++;
         $display("FAIL reset_release got %b exp 0", {vld, pend, ovf});
      end
   endtask

   task automatic test_single_pulse();
      do_reset();
      cyc(4'b0100, 1'b1, 1'b0);
      checks++;
      if (pend !== 4'b0100 || vld !== 1'b0) begin
         errors++;
         $display("FAIL pulse_pending got pend=%b vld=%b exp pend=0100 vld=0", pend, vld);
      end
      cyc(4'b0000, 1'b1, 1'b0);
      checks++;
      if ({vld, id, rise} !== {1'b1, 2'd2, 1'b1}) begin
         errors++;
         $display("FAIL pulse_offer got vld=%b id=%0d rise=%b exp 1/2/1", vld, id, rise);
      end
      cyc(4'b0000, 1'b1, 1'b0);
      checks++;
      if ({vld, pend, ovf} !== '0) begin
         errors++;
         $display("FAIL pulse_drain got vld=%b pend=%b ovf=%b exp all 0", vld, pend, ovf);
      end
   endtask

   task automatic test_round_robin();
      int gid[$];
      int gcy[$];
      int exp_a[4] = '{0, 1, 2, 3};
      int exp_b[4] = '{2, 3, 0, 1};
      do_reset();
      for (int c = 0; c < 12; c++) begin
         if (vld) begin gid.push_back(int'(id)); gcy.push_back(c); end
         cyc(4'b1111, 1'b1, 1'b0);
      end
      checks++;
      if (gid.size() != 4) begin
         errors++;
         $display("FAIL rr_count_a got %0d exp 4", gid.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (gid[k] != exp_a[k]) begin
               errors++;
               $display("FAIL rr_order_a[%0d] got %0d exp %0d", k, gid[k], exp_a[k]);
            end
         end
         for (int k = 1; k < 4; k++) begin
            checks++;
            if (gcy[k] - gcy[k-1] != 2) begin
               errors++;
               $display("FAIL rr_spacing[%0d] got %0d exp 2", k, gcy[k] - gcy[k-1]);
            end
         end
      end
      // Leave last_grant at 1, then request everything again.
      do_reset();
      cyc(4'b0010, 1'b1, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0);
      gid.delete();
      for (int c = 0; c < 12; c++) begin
         if (vld) gid.push_back(int'(id));
         cyc(4'b1111, 1'b1, 1'b0);
      end
      checks++;
      if (gid.size() != 4) begin
         errors++;
         $display("FAIL rr_count_b got %0d exp 4", gid.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (gid[k] != exp_b[k]) begin
               errors++;
               $display("FAIL rr_order_b[%0d] got %0d exp %0d", k, gid[k], exp_b[k]);
            end
         end
      end
   endtask

   task automatic test_hold_overflow();
      logic [N-1:0] seq[4] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000};
      logic [N-1:0] eovf[4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         cyc(seq[c], 1'b0, 1'b0);
         if (c >= 1) begin
            checks++;
            if ({vld, id} !== {1'b1, 2'd1}) begin
               errors++;
               $display("FAIL hold_stable c%0d got vld=%b id=%0d exp 1/1", c, vld, id);
            end
         end
         checks++;
         if (ovf !== eovf[c]) begin
            errors++;
            $display("FAIL hold_ovf c%0d got %b exp %b", c, ovf, eovf[c]);
         end
      end
      cyc(4'b0000, 1'b0, 1'b1);
      checks++;
      if (ovf !== 4'b0000 || vld !== 1'b1) begin
         errors++;
         $display("FAIL ovf_clear got ovf=%b vld=%b exp 0000/1", ovf, vld);
      end
      cyc(4'b0000, 1'b1, 1'b0);
      checks++;
      if ({vld, pend} !== '0) begin
         errors++;
         $display("FAIL hold_drain got vld=%b pend=%b exp 0", vld, pend);
      end
   endtask

   task automatic test_set_wins();
      do_reset();
      cyc(4'b1000, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      cyc(4'b1000, 1'b1, 1'b0);
      checks++;
      if ({vld, pend, ovf} !== {1'b0, 4'b1000, 4'b0000}) begin
         errors++;
         $display("FAIL set_wins got vld=%b pend=%b ovf=%b exp 0/1000/0000", vld, pend, ovf);
      end
      cyc(4'b0000, 1'b1, 1'b0);
      checks++;
      if ({vld, id} !== {1'b1, 2'd3}) begin
         errors++;
         $display("FAIL set_wins_regrant got vld=%b id=%0d exp 1/3", vld, id);
      end
      cyc(4'b0000, 1'b1, 1'b0);
      checks++;
      if (pend !== 4'b0000) begin
         errors++;
         $display("FAIL set_wins_drain got %b exp 0000", pend);
      end
   endtask

   task automatic test_reset_mid_offer();
      int gid[$];
      int exp_g[3] = '{0, 1, 3};
      do_reset();
      cyc(4'b1011, 1'b0, 1'b0);
      cyc(4'b1011, 1'b0, 1'b0);
      checks++;
      if ({vld, id, pend} !== {1'b1, 2'd0, 4'b1011}) begin
         errors++;
         $display("FAIL pre_reset got vld=%b id=%0d pend=%b exp 1/0/1011", vld, id, pend);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({vld, pend, ovf} !== '0) begin
         errors++;
         $display("FAIL async_reset got vld=%b pend=%b ovf=%b exp 0", vld, pend, ovf);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (vld) gid.push_back(int'(id));
         cyc(4'b1011, 1'b1, 1'b0);
      end
      checks++;
      if (gid.size() != 3) begin
         errors++;
         $display("FAIL post_reset_count got %0d exp 3", gid.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (gid[k] != exp_g[k]) begin
               errors++;
               $display("FAIL post_reset_order[%0d] got %0d exp %0d", k, gid[k], exp_g[k]);
            end
         end
      end
   endtask

   task automatic test_falling();
      int gid[$];
      bit grs[$];
      int nexp;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         if (vld) begin gid.push_back(int'(id)); grs.push_back(rise); end
         cyc((c < 4) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
      end
      nexp = FALL_EN ? 2 : 1;
      checks++;
      if (gid.size() != nexp) begin
         errors++;
         $display("FAIL falling_count got %0d exp %0d", gid.size(), nexp);
      end else begin
         for (int k = 0; k < nexp; k++) begin
            checks++;
            if (gid[k] != 1 || grs[k] != (k == 0)) begin
               errors++;
               $display("FAIL falling_event[%0d] got id=%0d rise=%0d exp id=1 rise=%0d",
                        k, gid[k], grs[k], (k == 0));
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [N-1:0] l;
      logic [2*N+IDW+1:0] got, expv;
      do_reset();
      l = '0;
      for (int c = 0; c < 400; c++) begin
         r = $urandom & $urandom;
         l = l ^ r[N-1:0];
         cyc(l, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
         got  = {vld, vld ? id : 2'd0, vld ? rise : 1'b0, pend, ovf};
         expv = {m_valid, m_valid ? IDW'(m_id) : 2'd0, m_valid ? m_rise : 1'b0, m_pend, m_ovf};
         checks++;
         if (got !== expv) begin
            errors++;
            $display("FAIL random c%0d got %b exp %b (vld,id,rise,pend,ovf)", c, got, expv);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_pulse();
      test_round_robin();
      test_hold_overflow();
      test_set_wins();
      test_reset_mid_offer();
      test_falling();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
